// File: rtl/kv_lookup_if.sv
// Bundle of the lookup controller's request/response, cache, backing-memory and statistics signals.
// The master side is the controller; the slave side is its environment.
`timescale 1ns/1ps
interface kv_lookup_if #(
    parameter int unsigned CNT_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [7:0]       req_key;
    logic             resp_valid;
    logic             resp_ready;
    logic [7:0]       resp_value;
    logic             resp_hit;
    logic             resp_err;
    logic             cache_find;
    logic [7:0]       cache_key;
    logic             cache_match_found;
    logic [7:0]       cache_value;
    logic             cache_update;
    logic [7:0]       cache_update_key;
    logic [7:0]       cache_update_value;
    logic             mem_req_valid;
    logic             mem_req_ready;
    logic [7:0]       mem_req_key;
    logic             mem_rsp_valid;
    logic [7:0]       mem_rsp_value;
    logic             busy;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    modport master (
        input  req_valid, req_key, resp_ready, cache_match_found, cache_value,
               mem_req_ready, mem_rsp_valid, mem_rsp_value,
        output req_ready, resp_valid, resp_value, resp_hit, resp_err,
               cache_find, cache_key, cache_update, cache_update_key, cache_update_value,
               mem_req_valid, mem_req_key, busy, hit_cnt, miss_cnt
    );

    modport slave (
        output req_valid, req_key, resp_ready, cache_match_found, cache_value,
               mem_req_ready, mem_rsp_valid, mem_rsp_value,
        input  req_ready, resp_valid, resp_value, resp_hit, resp_err,
               cache_find, cache_key, cache_update, cache_update_key, cache_update_value,
               mem_req_valid, mem_req_key, busy, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/kv_lookup_ctrl.sv
// Single-outstanding key/value lookup: probe the cache, on miss fetch from backing memory,
// fill the cache and respond; bounded memory wait yields an error response.
`timescale 1ns/1ps
module kv_lookup_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    kv_lookup_if.master kv
);
    localparam int unsigned KEY_W = 8;
    localparam int unsigned VAL_W = 8;
    localparam int unsigned TO_W  = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE, LOOKUP, CHECK, MISS_REQ, MISS_WAIT, FILL, RESP
    } state_t;

    state_t           r_state, w_nxt_state;
    logic [KEY_W-1:0] r_key, w_key;
    logic [VAL_W-1:0] r_value, w_value;
    logic             r_hit, w_hit;
    logic             r_err, w_err;
    logic [TO_W-1:0]  r_to_cnt, w_to_cnt;
    logic [CNT_W-1:0] r_hit_cnt, w_hit_cnt;
    logic [CNT_W-1:0] r_miss_cnt, w_miss_cnt;

    logic r_req_ready, r_resp_valid, r_cache_find, r_cache_update, r_mem_req_valid, r_busy;

    // Next state and next data; everything holds unless the current state says otherwise.
    always_comb begin
        w_nxt_state = r_state;
        w_key       = r_key;
        w_value     = r_value;
        w_hit       = r_hit;
        w_err       = r_err;
        w_to_cnt    = r_to_cnt;
        w_hit_cnt   = r_hit_cnt;
        w_miss_cnt  = r_miss_cnt;
        case (r_state)
            IDLE: begin
                if (kv.req_valid && r_req_ready) begin
                    w_key       = kv.req_key;
                    w_value     = '0;
                    w_hit       = 1'b0;
                    w_err       = 1'b0;
                    w_nxt_state = LOOKUP;
                end
            end
            LOOKUP: w_nxt_state = CHECK;
            CHECK: begin
                if (kv.cache_match_found) begin
                    w_value     = kv.cache_value;
                    w_hit       = 1'b1;
                    if (r_hit_cnt != CNT_MAX) w_hit_cnt = r_hit_cnt + CNT_W'(1);
                    w_nxt_state = RESP;
                end else begin
                    if (r_miss_cnt != CNT_MAX) w_miss_cnt = r_miss_cnt + CNT_W'(1);
                    w_nxt_state = MISS_REQ;
                end
            end
            MISS_REQ: begin
                if (kv.mem_req_ready) begin
                    w_to_cnt    = '0;
                    w_nxt_state = MISS_WAIT;
                end
            end
            MISS_WAIT: begin
                // A response arriving in the final wait cycle still beats the timeout.
                if (kv.mem_rsp_valid) begin
                    w_value     = kv.mem_rsp_value;
                    w_nxt_state = FILL;
                end else if (r_to_cnt == TO_LAST) begin
                    w_value     = '0;
                    w_err       = 1'b1;
                    w_nxt_state = RESP;
                end else begin
                    w_to_cnt = r_to_cnt + TO_W'(1);
                end
            end
            FILL: w_nxt_state = RESP;
            RESP: begin
                if (kv.resp_ready) w_nxt_state = IDLE;
            end
            default: w_nxt_state = IDLE;
        endcase
    end

    // State, data and outputs registered together; outputs are decoded from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_key           <= '0;
            r_value         <= '0;
            r_hit           <= 1'b0;
            r_err           <= 1'b0;
            r_to_cnt        <= '0;
            r_hit_cnt       <= '0;
            r_miss_cnt      <= '0;
            r_req_ready     <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_cache_find    <= 1'b0;
            r_cache_update  <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_state         <= w_nxt_state;
            r_key           <= w_key;
            r_value         <= w_value;
            r_hit           <= w_hit;
            r_err           <= w_err;
            r_to_cnt        <= w_to_cnt;
            r_hit_cnt       <= w_hit_cnt;
            r_miss_cnt      <= w_miss_cnt;
            r_req_ready     <= (w_nxt_state == IDLE);
            r_resp_valid    <= (w_nxt_state == RESP);
            r_cache_find    <= (w_nxt_state == LOOKUP);
            r_cache_update  <= (w_nxt_state == FILL);
            r_mem_req_valid <= (w_nxt_state == MISS_REQ);
            r_busy          <= (w_nxt_state != IDLE);
        end
    end

    assign kv.req_ready          = r_req_ready;
    assign kv.resp_valid         = r_resp_valid;
    assign kv.resp_value         = r_value;
    assign kv.resp_hit           = r_hit;
    assign kv.resp_err           = r_err;
    assign kv.cache_find         = r_cache_find;
    assign kv.cache_key          = r_key;
    assign kv.cache_update       = r_cache_update;
    assign kv.cache_update_key   = r_key;
    assign kv.cache_update_value = r_value;
    assign kv.mem_req_valid      = r_mem_req_valid;
    assign kv.mem_req_key        = r_key;
    assign kv.busy               = r_busy;
    assign kv.hit_cnt            = r_hit_cnt;
    assign kv.miss_cnt           = r_miss_cnt;
endmodule

// File: tb/tb_kv_lookup_ctrl.sv
// Scoreboard bench for kv_lookup_ctrl: default-parameter instance (A) plus a TIMEOUT=4, CNT_W=2 instance (B).
`timescale 1ns/1ps
module tb_kv_lookup_ctrl;
    logic clk = 1'b0;
    logic reset, sel, preload;
    always #5 clk = ~clk;

    kv_lookup_if #(.CNT_W(16)) kv_a ();
    kv_lookup_if #(.CNT_W(2))  kv_b ();

    kv_lookup_ctrl #(.CNT_W(16), .TIMEOUT(255)) dut_a (.clk(clk), .reset(reset), .kv(kv_a));
    kv_lookup_ctrl #(.CNT_W(2),  .TIMEOUT(4))   dut_b (.clk(clk), .reset(reset), .kv(kv_b));

    logic        req_valid, resp_ready, mem_req_ready, mem_rsp_valid, cache_match_found;
    logic [7:0]  req_key, mem_rsp_value, cache_value;
    logic        req_ready, resp_valid, resp_hit, resp_err, cache_find, cache_update, mem_req_valid, busy;
    logic [7:0]  resp_value, cache_key, cache_update_key, cache_update_value, mem_req_key;
    logic [31:0] hit_cnt, miss_cnt;

    // Only the selected instance sees requests; outputs are viewed through the same select.
    assign kv_a.req_valid = req_valid & ~sel;
    assign kv_b.req_valid = req_valid & sel;
    assign kv_a.req_key = req_key;                       assign kv_b.req_key = req_key;
    assign kv_a.resp_ready = resp_ready;                 assign kv_b.resp_ready = resp_ready;
    assign kv_a.mem_req_ready = mem_req_ready;           assign kv_b.mem_req_ready = mem_req_ready;
    assign kv_a.mem_rsp_valid = mem_rsp_valid;           assign kv_b.mem_rsp_valid = mem_rsp_valid;
    assign kv_a.mem_rsp_value = mem_rsp_value;           assign kv_b.mem_rsp_value = mem_rsp_value;
    assign kv_a.cache_match_found = cache_match_found;   assign kv_b.cache_match_found = cache_match_found;
    assign kv_a.cache_value = cache_value;               assign kv_b.cache_value = cache_value;

    assign req_ready          = sel ? kv_b.req_ready          : kv_a.req_ready;
    assign resp_valid         = sel ? kv_b.resp_valid         : kv_a.resp_valid;
    assign resp_value         = sel ? kv_b.resp_value         : kv_a.resp_value;
    assign resp_hit           = sel ? kv_b.resp_hit           : kv_a.resp_hit;
    assign resp_err           = sel ? kv_b.resp_err           : kv_a.resp_err;
    assign cache_find         = sel ? kv_b.cache_find         : kv_a.cache_find;
    assign cache_key          = sel ? kv_b.cache_key          : kv_a.cache_key;
    assign cache_update       = sel ? kv_b.cache_update       : kv_a.cache_update;
    assign cache_update_key   = sel ? kv_b.cache_update_key   : kv_a.cache_update_key;
    assign cache_update_value = sel ? kv_b.cache_update_value : kv_a.cache_update_value;
    assign mem_req_valid      = sel ? kv_b.mem_req_valid      : kv_a.mem_req_valid;
    assign mem_req_key        = sel ? kv_b.mem_req_key        : kv_a.mem_req_key;
    assign busy               = sel ? kv_b.busy               : kv_a.busy;
    assign hit_cnt            = sel ? 32'(kv_b.hit_cnt)       : 32'(kv_a.hit_cnt);
    assign miss_cnt           = sel ? 32'(kv_b.miss_cnt)      : 32'(kv_a.miss_cnt);

    // Cache model: result one cycle after find; preload holds key i -> i+50 for i=1..8.
    logic [7:0] cmem [256];
    logic       cvld [256];
    always @(posedge clk) begin
        cache_match_found <= cache_find && cvld[cache_key];
        cache_value       <= cache_find ? cmem[cache_key] : 8'h00;
        if (preload) begin
            for (int i = 0; i < 256; i++) begin
                cvld[i] <= (i >= 1 && i <= 8);
                cmem[i] <= 8'(i + 50);
            end
        end else if (cache_update) begin
            cvld[cache_update_key] <= 1'b1;
            cmem[cache_update_key] <= cache_update_value;
        end
    end

    typedef struct packed { logic [7:0] v; logic h; logic e; } resp_t;
    typedef struct packed { logic [7:0] k; logic [7:0] v; } upd_t;
    resp_t resp_q[$];
    upd_t  upd_q[$];
    resp_t mon_r;
    upd_t  mon_u;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: compare each accepted response and each cache fill against the scoreboard.
    always @(negedge clk) begin
        if (!reset && resp_valid && resp_ready) begin
            if (resp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_resp: got value %0h, expected no response", resp_value);
            end else begin
                mon_r = resp_q.pop_front();
                chk("resp_value", 32'(resp_value), 32'(mon_r.v));
                chk("resp_hit",   32'(resp_hit),   32'(mon_r.h));
                chk("resp_err",   32'(resp_err),   32'(mon_r.e));
            end
        end
        if (!reset && cache_update) begin
            if (upd_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_update: got key %0h, expected no update", cache_update_key);
            end else begin
                mon_u = upd_q.pop_front();
                chk("upd_key",   32'(cache_update_key),   32'(mon_u.k));
                chk("upd_value", 32'(cache_update_value), 32'(mon_u.v));
            end
        end
        if (cache_find && cache_update) begin
            n_checks++;
            $display("FAIL find_update_overlap: got both high, expected at most one");
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; preload = 1'b1; req_valid = 1'b0; resp_ready = 1'b1;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_value = 8'h00;
        tick();
        @(negedge clk);
        chk("rst_req_ready",  32'(req_ready), 0);
        chk("rst_busy",       32'(busy), 0);
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_mem_req",    32'(mem_req_valid), 0);
        chk("rst_resp_value", 32'(resp_value), 0);
        chk("rst_counts",     hit_cnt | miss_cnt, 0);
        tick();
        reset = 1'b0; preload = 1'b0;
        tick();
        chk("post_rst_req_ready", 32'(req_ready), 1);
    endtask

    task automatic send_req(input logic [7:0] key);
        req_valid = 1'b1; req_key = key;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (req_ready) break;
        end
        chk("req_accept", 32'(req_ready), 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_mem_req();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_req_valid) break;
        end
        chk("mem_req_seen", 32'(mem_req_valid), 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_reached", 32'(busy), 0);
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within 1 ms");
        $fatal(1);
    end

    initial begin
        sel = 1'b0; req_key = 8'h00;
        do_reset();

        // Hit on preloaded key 0x03 with exact latency.
        resp_q.push_back('{v: 8'h35, h: 1'b1, e: 1'b0});
        send_req(8'h03);
        @(negedge clk);
        chk("hit_find",     32'(cache_find), 1);
        chk("hit_find_key", 32'(cache_key), 32'h03);
        chk("hit_t1_valid", 32'(resp_valid), 0);
        @(negedge clk);
        chk("hit_t2_valid", 32'(resp_valid), 0);
        chk("hit_t2_find",  32'(cache_find), 0);
        @(negedge clk);
        chk("hit_t3_valid", 32'(resp_valid), 1);
        wait_idle();
        chk("hit_cnt_1", hit_cnt, 1);
        chk("q_empty_hit", 32'(resp_q.size()), 0);

        // Miss on 0x20, memory answers 0xAB five cycles into the wait.
        mem_req_ready = 1'b1;
        upd_q.push_back('{k: 8'h20, v: 8'hAB});
        resp_q.push_back('{v: 8'hAB, h: 1'b0, e: 1'b0});
        send_req(8'h20);
        wait_mem_req();
        chk("miss_mem_key", 32'(mem_req_key), 32'h20);
        chk("miss_cnt_1", miss_cnt, 1);
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1; mem_rsp_valid = 1'b1; mem_rsp_value = 8'hAB;
        tick(); mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("fill_update", 32'(cache_update), 1);
        chk("fill_no_resp", 32'(resp_valid), 0);
        @(negedge clk);
        chk("fill_update_once", 32'(cache_update), 0);
        chk("fill_resp_valid", 32'(resp_valid), 1);
        wait_idle();
        resp_q.push_back('{v: 8'hAB, h: 1'b1, e: 1'b0});
        send_req(8'h20);
        wait_idle();
        chk("hit_cnt_2", hit_cnt, 2);
        chk("q_empty_miss", 32'(resp_q.size() + upd_q.size()), 0);

        // Backpressure: memory request held 3 cycles, response held 10 cycles.
        mem_req_ready = 1'b0; resp_ready = 1'b0;
        upd_q.push_back('{k: 8'h55, v: 8'h99});
        resp_q.push_back('{v: 8'h99, h: 1'b0, e: 1'b0});
        send_req(8'h55);
        wait_mem_req();
        repeat (2) begin
            @(negedge clk);
            chk("bp_mem_valid", 32'(mem_req_valid), 1);
            chk("bp_mem_key",   32'(mem_req_key), 32'h55);
            chk("bp_req_ready", 32'(req_ready), 0);
        end
        tick(); mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_rsp_valid = 1'b1; mem_rsp_value = 8'h99;
        tick(); mem_rsp_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) break;
        end
        repeat (10) begin
            chk("bp_resp_valid", 32'(resp_valid), 1);
            chk("bp_resp_value", 32'(resp_value), 32'h99);
            chk("bp_resp_hit",   32'(resp_hit), 0);
            chk("bp_req_ready0", 32'(req_ready), 0);
            @(negedge clk);
        end
        tick(); resp_ready = 1'b1;
        wait_idle();
        chk("q_empty_bp", 32'(resp_q.size() + upd_q.size()), 0);

        // Reset while waiting on memory; a late memory response must be ignored.
        send_req(8'h40);
        wait_mem_req();
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_value = 8'h77;
        tick(); tick();
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("abort_busy",      32'(busy), 0);
        chk("abort_req_ready", 32'(req_ready), 1);
        chk("abort_resp",      32'(resp_valid), 0);
        chk("abort_hit_cnt",   hit_cnt, 0);
        chk("abort_miss_cnt",  miss_cnt, 0);
        tick();

        // Instance B: timeout after exactly 4 wait cycles.
        sel = 1'b1;
        do_reset();
        mem_req_ready = 1'b1;
        resp_q.push_back('{v: 8'h00, h: 1'b0, e: 1'b1});
        send_req(8'h40);
        wait_mem_req();
        @(posedge clk);
        repeat (4) begin
            @(negedge clk);
            chk("to_wait_no_resp", 32'(resp_valid), 0);
        end
        @(negedge clk);
        chk("to_resp_valid", 32'(resp_valid), 1);
        wait_idle();

        // Memory response in the expiry cycle wins over the timeout.
        upd_q.push_back('{k: 8'h41, v: 8'h5A});
        resp_q.push_back('{v: 8'h5A, h: 1'b0, e: 1'b0});
        send_req(8'h41);
        wait_mem_req();
        @(posedge clk);
        repeat (3) @(posedge clk);
        #1; mem_rsp_valid = 1'b1; mem_rsp_value = 8'h5A;
        tick(); mem_rsp_valid = 1'b0;
        @(negedge clk);
        chk("expiry_fill", 32'(cache_update), 1);
        wait_idle();
        chk("b_miss_cnt", miss_cnt, 2);

        // Saturation: five hits on a 2-bit counter.
        for (int i = 1; i <= 5; i++) begin
            resp_q.push_back('{v: 8'(i + 50), h: 1'b1, e: 1'b0});
            send_req(8'(i));
            wait_idle();
            chk("sat_hit_cnt", hit_cnt, (i > 3) ? 32'd3 : 32'(i));
        end
        chk("q_empty_end", 32'(resp_q.size() + upd_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/kv_lookup_ctrl.md
KV_LOOKUP_CTRL -- requirements
Module: kv_lookup_ctrl

Interface
REQ-001 SHALL have parameter: CNT_W, 16, width of hit/miss counters.
REQ-002 SHALL have parameter: TIMEOUT, 255, max cycles in MISS_WAIT before error response (1..2^16-1).
REQ-003 SHALL have ports: clk  in  1  clock; all logic on rising edge.
REQ-004 SHALL have ports: reset  in  1  synchronous, active-high.
REQ-005 SHALL have ports: req_valid/req_ready  in/out  1  lookup request handshake; req_key  in  8  key.
REQ-006 SHALL have ports: resp_valid/resp_ready  out/in  1  response handshake; resp_value  out  8; resp_hit  out  1; resp_err  out  1.
REQ-007 SHALL have ports: cache_find  out  1; cache_key  out  8; cache_match_found  in  1; cache_value  in  8 (cache result valid exactly 1 cycle after find).
REQ-008 SHALL have ports: cache_update  out  1; cache_update_key  out  8; cache_update_value  out  8.
REQ-009 SHALL have ports: mem_req_valid/mem_req_ready  out/in  1; mem_req_key  out  8; mem_rsp_valid  in  1; mem_rsp_value  in  8.
REQ-010 SHALL have ports: busy  out  1; hit_cnt, miss_cnt  out  CNT_W  statistics.

Function
REQ-011 SHALL implement FSM states IDLE, LOOKUP, CHECK, MISS_REQ, MISS_WAIT, FILL, RESP; all outputs decoded from registered state/data, no input-to-output combinational path.
REQ-012 IDLE: req_ready=1; on req_valid capture req_key into key_q -> LOOKUP.
REQ-013 LOOKUP: cache_find=1, cache_key=key_q for exactly one cycle -> CHECK.
REQ-014 CHECK: sample cache_match_found/cache_value; hit -> capture value, hit_q=1, hit_cnt++ -> RESP; miss -> miss_cnt++ -> MISS_REQ.
REQ-015 MISS_REQ: mem_req_valid=1, mem_req_key=key_q held stable until mem_req_ready; on ready -> MISS_WAIT, timeout counter cleared.
REQ-016 MISS_WAIT: on mem_rsp_valid capture mem_rsp_value -> FILL; mem_rsp_valid outside MISS_WAIT SHALL be ignored.
REQ-017 MISS_WAIT timeout: after TIMEOUT cycles without mem_rsp_valid -> RESP with resp_err=1, resp_value=0, resp_hit=0, no FILL; mem_rsp_valid in the expiry cycle wins over timeout.
REQ-018 FILL: cache_update=1 for exactly one cycle with key_q/value_q -> RESP.
REQ-019 RESP: resp_valid=1, resp_value/resp_hit/resp_err held stable until resp_ready; on resp_ready -> IDLE.
REQ-020 cache_find and cache_update SHALL never be asserted in the same cycle.
REQ-021 Hit latency: request accepted at edge T -> resp_valid high from cycle T+3 (LOOKUP T+1, CHECK T+2).
REQ-022 Miss latency: resp_valid asserts 2 cycles after mem_rsp_valid accepted (FILL, then RESP).
REQ-023 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-024 busy=1 in every state except IDLE.
REQ-025 One request in flight maximum; req_ready=0 outside IDLE.

Reset
REQ-026 reset SHALL force IDLE from any state in the following cycle, abandoning any in-flight request with no response.
REQ-027 reset values: req_ready=0 during reset, 1 after; resp_valid, resp_hit, resp_err, cache_find, cache_update, mem_req_valid, busy=0; resp_value, cache_key, cache_update_key/value, mem_req_key=0; hit_cnt=miss_cnt=0; timeout counter=0.
REQ-028 mem_rsp_valid arriving after a reset-aborted miss SHALL be ignored and SHALL NOT update the cache.

Verification
REQ-029 Hit: after reset (cache holds key i -> i+50, i=1..8), req_key=0x03 -> resp_valid at T+3, resp_value=0x35, resp_hit=1, hit_cnt=1.
REQ-030 Miss+fill: req_key=0x20, mem_req_ready at once, mem_rsp_value=0xAB 5 cycles later -> one-cycle cache_update 0x20/0xAB, resp_value=0xAB, resp_hit=0, miss_cnt=1; repeat 0x20 -> hit, 0xAB.
REQ-031 Timeout: TIMEOUT=4, miss on 0x40, no mem_rsp_valid -> resp_err=1, resp_value=0, no cache_update; mem_rsp_valid in expiry cycle -> normal fill instead.
REQ-032 Backpressure: resp_ready low 10 cycles, mem_req_ready low 3 cycles -> outputs stable, req_ready=0 throughout, single response.
REQ-033 Reset in MISS_WAIT, then late mem_rsp_valid=0x77 -> state IDLE, no cache_update, no resp_valid, counters 0.
REQ-034 Saturation: CNT_W=2, 5 hits -> hit_cnt=3.
